// File: rtl/demux_channel_collector.sv
// Collects demux channel words into one slot per channel and drains them round-robin to a valid/ready stream.
// Latency 1 cycle from capture to out_valid; full slots drop new writes and count them. Optional COLLECTOR_PARITY_EN adds out_parity.
module demux_channel_collector #(
    parameter int DATA_W = 8,
    parameter int OVF_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_c,
    input  logic [DATA_W-1:0] in_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_ch,
    output logic [OVF_W-1:0]  ovf_count,
    output logic              ovf_flag,
`ifdef COLLECTOR_PARITY_EN
    output logic              out_parity,
`endif
    input  logic              clr_ovf
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] slot_data [4];
    logic [3:0]        slot_full;
    logic [1:0]        rr_ptr;

    logic              take;
    logic              grant_vld;
    logic [1:0]        grant;
    logic              unload;
    logic              drop;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    // The output register can accept a new word when empty or when its word leaves this cycle.
    assign take = (state == IDLE) || out_ready;

    always_comb begin
        logic [1:0] idx;
        grant_vld = 1'b0;
        grant     = rr_ptr;
        idx       = rr_ptr;
        // Walk backwards so the candidate nearest rr_ptr is the one left standing.
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (slot_full[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign unload = take && grant_vld;

    always_comb begin
        wr_data = in_a;
        case (in_sel)
            2'd0: wr_data = in_a;
            2'd1: wr_data = in_b;
            2'd2: wr_data = in_c;
            default: wr_data = in_d;
        endcase
    end

    // A slot emptied on this edge can take the new word without counting an overflow.
    assign drop  = in_valid && slot_full[in_sel] && !(unload && (grant == in_sel));
    assign wr_en = in_valid && !drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                slot_data[i] <= '0;
            end
            slot_full <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_en && (in_sel == 2'(i))) begin
                    slot_data[i] <= wr_data;
                    slot_full[i] <= 1'b1;
                end else if (unload && (grant == 2'(i))) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            out_data <= '0;
            out_ch   <= 2'd0;
`ifdef COLLECTOR_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (unload) begin
            state    <= PRESENT;
            rr_ptr   <= grant + 2'd1;
            out_data <= slot_data[grant];
            out_ch   <= grant;
`ifdef COLLECTOR_PARITY_EN
            out_parity <= ^slot_data[grant];
`endif
        end else if ((state == PRESENT) && out_ready) begin
            state <= IDLE;
        end
    end

    assign out_valid = (state == PRESENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
            ovf_flag  <= 1'b0;
        end else if (clr_ovf) begin
            ovf_count <= '0;
            ovf_flag  <= 1'b0;
        end else if (drop) begin
            ovf_flag <= 1'b1;
            if (ovf_count != {OVF_W{1'b1}}) begin
                ovf_count <= ovf_count + 1'b1;
            end
        end
    end

endmodule
